// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: the instruction word
// layout, the sequencer state encoding and the decoded field bundle.
package instr_sequencer_pkg;

  // Instruction word width, fixed by the field layout below.
  localparam int INSTR_W = 20;

  // Bit positions of each field inside an instruction word.
  localparam int F_MSB      = 19;
  localparam int F_LSB      = 17;
  localparam int ASEL_BIT   = 16;
  localparam int WEN_BIT    = 15;
  localparam int WADDR_MSB  = 14;
  localparam int WADDR_LSB  = 13;
  localparam int RA_MSB     = 12;
  localparam int RA_LSB     = 11;
  localparam int RB_MSB     = 10;
  localparam int RB_LSB     = 9;
  localparam int HALT_BIT   = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  // One instruction word split into its named fields.
  typedef struct packed {
    logic [2:0] f;
    logic       aSel;
    logic       wEn;
    logic [1:0] wAddr;
    logic [1:0] raAddr;
    logic [1:0] rbAddr;
    logic       halt;
    logic [7:0] imm;
  } instr_fields_t;

  // All-zero field bundle, used as the reset value of the output registers.
  localparam instr_fields_t FIELDS_ZERO = '0;

  // Split a raw word into fields by position.
  function automatic instr_fields_t decodeWord(input logic [INSTR_W-1:0] word);
    instr_fields_t fields;
    fields.f      = word[F_MSB:F_LSB];
    fields.aSel   = word[ASEL_BIT];
    fields.wEn    = word[WEN_BIT];
    fields.wAddr  = word[WADDR_MSB:WADDR_LSB];
    fields.raAddr = word[RA_MSB:RA_LSB];
    fields.rbAddr = word[RB_MSB:RB_LSB];
    fields.halt   = word[HALT_BIT];
    fields.imm    = word[IMM_MSB:IMM_LSB];
    return fields;
  endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Purely combinational instruction decoder: raw instruction word in,
// named control fields out. Shared by the sequencer and the assembler bench.
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] i_word,
  output instr_fields_t      o_fields
);

  // Field split is a fixed rewiring of the word bits.
  always_comb begin
    o_fields = decodeWord(i_word);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from a synchronous instruction memory,
// registers the decoded control fields and drives the datapath control bundle.
// Two cycles per instruction (FETCH then EXEC); supports continuous run,
// single step and halt-on-flag with a clear back to address zero.
module instr_sequencer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = instr_sequencer_pkg::INSTR_W
) (
  input  logic               Clock_50,
  input  logic               Resetn,
  input  logic               start,
  input  logic               step,
  input  logic               clr,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [1:0]         W_addr,
  output logic               W_en,
  output logic [1:0]         RA_addr,
  output logic [1:0]         RB_addr,
  output logic [7:0]         Imm,
  output logic               A_sel,
  output logic [2:0]         F,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted
);

  import instr_sequencer_pkg::*;

  seq_state_t    r_state;
  seq_state_t    w_nextState;
  logic          r_oneShot;
  logic          w_oneShotNext;
  logic [PC_W-1:0] r_pc;
  instr_fields_t r_fields;
  instr_fields_t w_decoded;
  logic          w_loadFields;
  logic          w_pcIncr;
  logic          w_pcClear;

  instr_decode u_decode (
    .i_word   (imem_data),
    .o_fields (w_decoded)
  );

  // Next-state logic and per-state control strobes.
  always_comb begin
    w_nextState   = r_state;
    w_oneShotNext = r_oneShot;
    w_loadFields  = 1'b0;
    w_pcIncr      = 1'b0;
    w_pcClear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState   = ST_FETCH;
          w_oneShotNext = 1'b0;
        end else if (step) begin
          w_nextState   = ST_FETCH;
          w_oneShotNext = 1'b1;
        end
      end
      ST_FETCH: begin
        w_loadFields = 1'b1;
        w_nextState  = ST_EXEC;
      end
      ST_EXEC: begin
        w_pcIncr = 1'b1;
        if (r_fields.halt) begin
          w_nextState   = ST_HALTED;
          w_oneShotNext = 1'b0;
        end else if (r_oneShot || !start) begin
          w_nextState   = ST_IDLE;
          w_oneShotNext = 1'b0;
        end else begin
          w_nextState = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (clr) begin
          w_nextState = ST_IDLE;
          w_pcClear   = 1'b1;
        end
      end
      default: begin
        w_nextState   = ST_IDLE;
        w_oneShotNext = 1'b0;
      end
    endcase
  end

  // State and one-shot flag registers.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_oneShot <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_oneShot <= w_oneShotNext;
    end
  end

  // Program counter: advances when an instruction retires, cleared from HALTED.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_pc <= '0;
    end else if (w_pcClear) begin
      r_pc <= '0;
    end else if (w_pcIncr) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  // Decoded fields are captured at the end of FETCH and held until the next one.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_fields <= FIELDS_ZERO;
    end else if (w_loadFields) begin
      r_fields <= w_decoded;
    end
  end

  // Write enable is only live during EXEC so idle or halted cycles never write.
  always_comb begin
    W_en = (r_state == ST_EXEC) && r_fields.wEn;
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign W_addr    = r_fields.wAddr;
  assign RA_addr   = r_fields.raAddr;
  assign RB_addr   = r_fields.rbAddr;
  assign Imm       = r_fields.imm;
  assign A_sel     = r_fields.aSel;
  assign F         = r_fields.f;
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);
  assign halted    = (r_state == ST_HALTED);

endmodule
